alu_serial_seq: RTL and testbench

Bit-serial WIDTH-bit ALU sequencer for area-reduced datapath variants. Latches a full operand pair plus a 4-bit ALU control word and processes one bit per clock, LSB first, using and/or/add/slt bit-slice logic with A/B inversion. Returns a word result with zero, cout and overflow flags, and a done pulse. Sits directly downstream of the ALU-control decode and upstream of the register write-back.

---
 rtl/alu_serial_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_serial_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial WIDTH-bit ALU sequencer.
// Latches an operand pair and a 4-bit ALU control word on an accepted start,
// then evaluates one bit per clock (LSB first) with and/or/add/slt bit-slice
// logic and optional A/B inversion. One extra FIN cycle resolves slt, the
// flags and the done pulse.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst_n        synchronous active-low reset
//   start        request, accepted only in IDLE
//   src1, src2   operands A/B, sampled on accepted start
//   ALU_control  {A_invert, B_invert, operation[1:0]}
//                (00 and, 01 or, 10 add, 11 slt)
//   busy         high during RUN and FIN
//   done         one-cycle pulse, result/flags valid from this cycle
//   result       registered result, held until the next accepted start
//   zero         result == 0
//   cout         carry out of MSB (add only)
//   overflow     signed overflow (add only)
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic             cout_msb_q, cout_msb_d;
  logic             smsb_q, smsb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Bit slice for the current index
  logic a_bit, b_bit, s_bit, c_next, bit_val;
  logic ovf, is_add;
  logic [WIDTH-1:0] res_fin;

  always_comb begin
    a_bit  = a_q[idx_q] ^ ctrl_q[3];
    b_bit  = b_q[idx_q] ^ ctrl_q[2];
    s_bit  = a_bit ^ b_bit ^ carry_q;
    c_next = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    case (ctrl_q[1:0])
      OP_AND:  bit_val = a_bit & b_bit;
      OP_OR:   bit_val = a_bit | b_bit;
      OP_ADD:  bit_val = s_bit;
      default: bit_val = 1'b0;          // slt: bit 0 patched in FIN
    endcase

    ovf    = cin_msb_q ^ cout_msb_q;
    is_add = (ctrl_q[1:0] == OP_ADD);
    res_fin = result_q;
    // slt: true sign of the subtraction is the sum MSB corrected by overflow
    if (ctrl_q[1:0] == 2'b11) res_fin[0] = smsb_q ^ ovf;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    cin_msb_d  = cin_msb_q;
    cout_msb_d = cout_msb_q;
    smsb_d     = smsb_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = src1;
          b_d      = src2;
          ctrl_d   = ALU_control;
          idx_d    = '0;
          carry_d  = ALU_control[2];    // +1 for two's-complement subtract
          result_d = '0;
          zero_d   = 1'b0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d[idx_q] = bit_val;
        carry_d         = c_next;
        idx_d           = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cin_msb_d  = carry_q;
          cout_msb_d = c_next;
          smsb_d     = s_bit;
          state_d    = S_FIN;
        end
      end
      S_FIN: begin
        result_d = res_fin;
        zero_d   = (res_fin == '0);
        cout_d   = is_add & cout_msb_q;
        ovf_d    = is_add & ovf;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      cin_msb_q  <= 1'b0;
      cout_msb_q <= 1'b0;
      smsb_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      cin_msb_q  <= cin_msb_d;
      cout_msb_q <= cout_msb_d;
      smsb_q     <= smsb_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed testbench for alu_serial_seq (WIDTH=32).
module tb_alu_serial_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src1, src2;
  logic [3:0]  ALU_control;
  logic        busy, done, zero, cout, overflow;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  int lat, bcnt;

  alu_serial_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src1(src1), .src2(src2),
    .ALU_control(ALU_control), .busy(busy), .done(done), .result(result),
    .zero(zero), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start for one edge; scramble operands afterwards since they must
  // not matter once latched.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    src1 = a; src2 = b; ALU_control = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
  endtask

  // Count edges until done (bounded); optionally pulse start with other
  // operands at edge poke_at.
  task automatic wait_done(input int poke_at, output int l, output int bc);
    l  = 0;
    bc = busy ? 1 : 0;
    while (!done && l < 60) begin
      if (l == poke_at) begin
        start = 1'b1; src1 = 32'd100; src2 = 32'd200; ALU_control = 4'b0010;
      end
      @(posedge clk); #1;
      start = 1'b0;
      l++;
      if (busy) bc++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] r, input logic z,
                         input logic co, input logic ov);
    chk({tag, " lat"},  32'(lat), 32'd33);
    chk({tag, " busy"}, 32'(bcnt), 32'd33);
    chk({tag, " res"},  result, r);
    chk({tag, " zero"}, {31'd0, zero}, {31'd0, z});
    chk({tag, " cout"}, {31'd0, cout}, {31'd0, co});
    chk({tag, " ovf"},  {31'd0, overflow}, {31'd0, ov});
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [3:0] c, input logic [31:0] r, input logic z,
                    input logic co, input logic ov);
    launch(a, b, c);
    wait_done(-1, lat, bcnt);
    chk_res(tag, r, z, co, ov);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src1 = '0; src2 = '0; ALU_control = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst res",  result, 32'd0);
    chk("rst zero", {31'd0, zero}, 32'd0);
    chk("rst cout", {31'd0, cout}, 32'd0);
    chk("rst ovf",  {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    // held in IDLE after done
    repeat (3) @(posedge clk);
    #1;
    chk("hold res",  result, 32'h8000_0000);
    chk("hold done", {31'd0, done}, 32'd0);

    op("sub_eq",  32'd5, 32'd5, 4'b0110, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    op("sub_neg", 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    op("slt_m1",  32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0);
    op("slt_min", 32'h8000_0000, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0);
    op("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 32'd0, 1'b1, 1'b0, 1'b0);
    op("and",     32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    op("or",      32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    op("nor",     32'd0, 32'd0, 4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    op("add_c",   32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1'b1, 1'b0);

    // start pulsed while busy is ignored
    launch(32'd3, 32'd4, 4'b0010);
    wait_done(10, lat, bcnt);
    chk_res("ignore", 32'd7, 1'b0, 1'b0, 1'b0);

    // back-to-back: start on the edge where done falls
    launch(32'd10, 32'd20, 4'b0010);
    chk("b2b done fall", {31'd0, done}, 32'd0);
    chk("b2b busy",      {31'd0, busy}, 32'd1);
    wait_done(-1, lat, bcnt);
    chk_res("b2b", 32'd30, 1'b0, 1'b0, 1'b0);

    // reset in the middle of RUN
    launch(32'd1, 32'd2, 4'b0010);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst busy", {31'd0, busy}, 32'd0);
    chk("mrst res",  result, 32'd0);
    chk("mrst done", {31'd0, done}, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      chk("mrst quiet", 32'(seen), 32'd0);
    end
    op("post_rst", 32'h1234_5678, 32'h1111_1111, 4'b0010, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
